// File: rtl/mem_arb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared types and constants for the two-port memory arbiter/sequencer.
//   - state_t   : sequencer states for one single-word memory operation
//   - req_id_t  : identifies which requester owns the current operation
//   - ADDR_W_DEF/DATA_W_DEF : default widths for the 64x64 memory
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 64;

   // One operation walks IDLE -> WR -> WR_HOLD -> IDLE for a write, or
   // IDLE -> RD -> RD_CAP -> TURN -> IDLE for a read.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      WR_HOLD = 3'd2,
      RD      = 3'd3,
      RD_CAP  = 3'd4,
      TURN    = 3'd5
   } state_t;

   // Requester 0 or requester 1.
   typedef logic req_id_t;

endpackage

// File: rtl/mem_arb_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter, purely combinational. The pointer register
// (last granted requester) lives in the parent; this block computes the
// one-hot selection and the pointer value to store when a grant happens.
//
// Ports:
//   req_i        in   2  request vector, bit n = requester n
//   last_gnt_i   in   1  requester granted most recently
//   advance_i    in   1  a grant is being taken this cycle
//   sel_o        out  2  one-hot selected requester (0 when no request)
//   last_gnt_o   out  1  pointer value for the next cycle
// ---------------------------------------------------------------------------
module rr_arb2
   import mem_ctrl_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_gnt_i,
   input  logic       advance_i,
   output logic [1:0] sel_o,
   output logic       last_gnt_o
);

   // A lone requester always wins; on a tie the requester that was not
   // granted last time wins, which gives strict alternation under load.
   always_comb begin
      sel_o = 2'b00;
      case (req_i)
         2'b01:   sel_o = 2'b01;
         2'b10:   sel_o = 2'b10;
         2'b11:   sel_o = last_gnt_i ? 2'b01 : 2'b10;
         default: sel_o = 2'b00;
      endcase
   end

   // The pointer only moves when a grant is actually taken.
   always_comb begin
      last_gnt_o = last_gnt_i;
      if (advance_i && (|req_i)) begin
         last_gnt_o = sel_o[1];
      end
   end

endmodule

// File: rtl/mem_arb_ctrl.sv
// ---------------------------------------------------------------------------
// mem_arb_ctrl
// Round-robin arbiter and sequencer in front of a 64x64 asynchronous memory
// with a shared bidirectional data bus. Two clocked requesters issue
// single-word reads/writes; one operation is in flight at a time.
//
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   req0/we0/addr0/wdata0      requester 0 request, direction, address, data
//   gnt0                       one-cycle pulse: requester 0 accepted
//   rvalid0/rdata0             read-data pulse and registered read data
//   req1 ... rdata1            same for requester 1
//   mem_addr                   memory address pins
//   mem_write/mem_read         memory write/read strobes
//   data_bus                   shared tri-state data bus
// ---------------------------------------------------------------------------
module mem_arb_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write,
   output logic              mem_read,
   inout  wire  [DATA_W-1:0] data_bus
);

   state_t            state_q, state_d;
   req_id_t           owner_q, owner_d;
   logic [ADDR_W-1:0] op_addr_q, op_addr_d;
   logic [DATA_W-1:0] op_wdata_q, op_wdata_d;
   logic              last_gnt_q, last_gnt_d;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;

   logic [1:0]        arb_sel;
   logic              arb_advance;
   logic              bus_drive;
   logic              sel_we;

   // Arbitration is only consulted while idle; busy-time requests simply
   // wait because the requester keeps req high until it sees its grant.
   rr_arb2 u_arb (
      .req_i      ({req1, req0}),
      .last_gnt_i (last_gnt_q),
      .advance_i  (arb_advance),
      .sel_o      (arb_sel),
      .last_gnt_o (last_gnt_d)
   );

   // State, operation latch and round-robin pointer. Reset drops any
   // in-flight operation and makes requester 0 win the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         op_addr_q  <= '0;
         op_wdata_q <= '0;
         last_gnt_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         op_addr_q  <= op_addr_d;
         op_wdata_q <= op_wdata_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   // Next-state logic. In IDLE the winning requester's fields are latched
   // so the requester is free to change them once it has its grant.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      op_addr_d   = op_addr_q;
      op_wdata_d  = op_wdata_q;
      arb_advance = 1'b0;
      sel_we      = arb_sel[1] ? we1 : we0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               arb_advance = 1'b1;
               owner_d     = arb_sel[1];
               op_addr_d   = arb_sel[1] ? addr1  : addr0;
               op_wdata_d  = arb_sel[1] ? wdata1 : wdata0;
               state_d     = sel_we ? WR : RD;
            end
         end
         WR:      state_d = WR_HOLD;
         WR_HOLD: state_d = IDLE;
         RD:      state_d = RD_CAP;
         RD_CAP:  state_d = TURN;
         TURN:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode straight from the registered state, so an asynchronous
   // reset forces every strobe low and releases the bus immediately.
   // The bus is driven only through WR/WR_HOLD, which never overlap the
   // read strobe, so the controller and memory never fight for the bus.
   always_comb begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      rvalid0   = 1'b0;
      rvalid1   = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      mem_addr  = '0;
      bus_drive = 1'b0;
      case (state_q)
         WR: begin
            gnt0      = ~owner_q;
            gnt1      = owner_q;
            mem_write = 1'b1;
            mem_addr  = op_addr_q;
            bus_drive = 1'b1;
         end
         WR_HOLD: begin
            mem_addr  = op_addr_q;
            bus_drive = 1'b1;
         end
         RD: begin
            gnt0     = ~owner_q;
            gnt1     = owner_q;
            mem_read = 1'b1;
            mem_addr = op_addr_q;
         end
         RD_CAP: begin
            mem_read = 1'b1;
            mem_addr = op_addr_q;
         end
         TURN: begin
            rvalid0 = ~owner_q;
            rvalid1 = owner_q;
         end
         default: begin
         end
      endcase
   end

   assign data_bus = bus_drive ? op_wdata_q : {DATA_W{1'bz}};

   // Read data is sampled at the end of RD_CAP, after the memory has had
   // two full cycles of read strobe; whatever is on the bus is kept as-is.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if (state_q == RD_CAP) begin
         if (owner_q) begin
            rdata1_q <= data_bus;
         end else begin
            rdata0_q <= data_bus;
         end
      end
   end

   assign rdata0 = rdata0_q;
   assign rdata1 = rdata1_q;

endmodule

// File: doc/mem_arb_ctrl.md
Name: mem_arb_ctrl

Overview:
- Two-port round-robin arbiter and sequencer in front of the 64x64 asynchronous memory with its shared bidirectional data bus.
- Accepts single-word read/write requests from two clocked requesters.
- Drives the memory's address, write-strobe and read-strobe pins, and owns the tri-state bus.
- Guarantees the controller never drives the bus while the memory's read strobe is high; returns registered read data with a valid pulse.

Parameters:
- ADDR_W, 6, memory address width (64 locations).
- DATA_W, 64, data bus / word width.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 request; held high until gnt0.
- we0  in  1  requester 0: 1 = write, 0 = read; valid with req0.
- addr0  in  ADDR_W  requester 0 address.
- wdata0  in  DATA_W  requester 0 write data.
- gnt0  out  1  one-cycle pulse: request 0 accepted.
- rvalid0  out  1  one-cycle pulse: rdata0 valid.
- rdata0  out  DATA_W  requester 0 read data; holds value until next read.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for requester 1.
- mem_addr  out  ADDR_W  memory address.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe.
- data_bus  inout  DATA_W  shared tri-state bus to memory.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; all outputs go to 0; data_bus is released (all Z).
  - last_gnt is set to 1, so requester 0 wins the first tie.
  - An in-flight operation is dropped: no gnt or rvalid is issued for it, and the write is not guaranteed to commit.
- States: IDLE, WR, WR_HOLD, RD, RD_CAP, TURN.
- IDLE:
  - Bus is released; mem_write = mem_read = 0.
  - On a clock edge with any req high, the arbiter selects one requester and latches its we/addr/wdata into op registers.
  - Next state is WR if we = 1, otherwise RD.
  - No request: stay in IDLE.
- Arbitration:
  - Only req0 or only req1: that requester is granted.
  - Both high: grant the requester not equal to last_gnt; last_gnt is updated on each grant.
- gnt_i: high for exactly the first cycle of WR or RD. The requester may drop req or change fields from the next cycle on.
- WR (1 cycle): mem_addr = latched addr; data_bus driven with latched wdata; mem_write = 1. Next state WR_HOLD.
- WR_HOLD (1 cycle): mem_write = 0; data_bus and mem_addr held for hold time. Next state IDLE.
- RD (1 cycle): bus released; mem_read = 1; mem_addr = latched addr. Next state RD_CAP.
- RD_CAP (1 cycle): mem_read stays 1; at the end of the cycle, data_bus is captured into the granted requester's rdata. Next state TURN.
- TURN (1 cycle): mem_read = 0; bus released (turnaround); rvalid_i = 1 for this cycle with the new rdata. Next state IDLE.
- Latency, counted from the accepting IDLE edge:
  - Write: gnt on cycle 1; memory updated during cycle 1; controller back in IDLE on cycle 3.
  - Read: gnt on cycle 1; rvalid on cycle 3; back in IDLE on cycle 4.
- Throughput: one write per 3 cycles, one read per 4 cycles. No pipelining or overlap of operations.
- Requests arriving while busy are ignored until IDLE; req must stay high, since nothing is queued.
- Invariants (bench asserts):
  - Controller drives data_bus only in WR and WR_HOLD.
  - mem_write and mem_read are never both high.
  - At most one gnt and one rvalid per cycle.
  - gnt and rvalid only go to the owner of the latched operation.
- Addresses wrap naturally within ADDR_W; no range check is done.
- X or Z on data_bus during RD_CAP is captured as-is.

Decomposition:
- Package mem_ctrl_pkg:
  - State enum (IDLE, WR, WR_HOLD, RD, RD_CAP, TURN).
  - ADDR_W/DATA_W default constants.
  - Requester-id type (1 bit).
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: req[1:0], last_gnt, advance.
  - Outputs: one-hot sel, updated last_gnt.
  - Combinational select, registered pointer.
- Top contains the FSM, op registers, tri-state driver and per-port rdata registers.

Test Plan:
- Reset then req0 write addr 6'h05, data 64'hDEAD_BEEF_0123_4567 → gnt0 in cycle 1; mem_write high exactly 1 cycle with data_bus = that value; memory location 5 updated; bus Z by cycle 3.
- req1 read addr 6'h05 after the write → mem_read high 2 cycles with no controller drive; rvalid1 on cycle 3 with rdata1 = 64'hDEAD_BEEF_0123_4567; rdata0 unchanged.
- req0 and req1 both held high continuously (reads of 6'h00 and 6'h3F) → grants alternate 0,1,0,1 after reset; each rdata matches its address's preloaded content.
- Back-to-back write then read by the same requester at addr 6'h3F, data 64'hFFFF_0000_FFFF_0000 → no cycle with both the controller driving and mem_read high; read returns the written data.
- rst asserted during RD_CAP → outputs 0 and bus Z immediately (asynchronous); no rvalid; a fresh req0 read after release completes normally.
- req1 raised during a req0 write → no gnt1 until IDLE; gnt1 arrives in the first cycle after the controller returns to IDLE.
